muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//  Iterative unsigned multiply/divide unit (MULTU/DIVU) producing HI/LO, one bit per clock.
//  Sits between the register-file read stage and ALU32: it drives ALU32's A, B and alu_op, and consumes S.
//  ALU32 performs every add/subtract step; carry and borrow are reconstructed here.
// PARAMETERS
//  WIDTH  32  operand width; fixed at 32 to match ALU32; other values are illegal
//  CNT_W  6   iteration counter width; must hold the value WIDTH
// PORTS
//  clk      in   1   clock, rising edge
//  reset    in   1   synchronous reset, active high
//  start    in   1   request; sampled only in IDLE
//  op       in   1   0 = MULTU, 1 = DIVU
//  rs_val   in   32  multiplicand / dividend
//  rt_val   in   32  multiplier / divisor
//  busy     out  1   high in the MUL and DIV states
//  done     out  1   one-cycle pulse; hi/lo are valid from this cycle on
//  hi       out  32  MULTU: product[63:32]; DIVU: remainder
//  lo       out  32  MULTU: product[31:0]; DIVU: quotient
//  div_zero out  1   set by DIVU with rt_val==0; cleared by the next accepted start or by reset
// BEHAVIOUR
//  Reset values: state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0, cnt=0.
//  Reset during MUL or DIV aborts the operation immediately; the partial result is discarded.
//  States and transitions:
//   IDLE -> MUL   on start && op==0
//   IDLE -> DIV   on start && op==1 && rt_val!=0
//   IDLE -> DONE  on start && op==1 && rt_val==0
//   MUL/DIV -> DONE  after the 32nd iteration (cnt==31)
//   DONE -> IDLE  always, one cycle later
//  start in any state other than IDLE is ignored; operands are not re-latched.
//  At accept: operand register D <= rt_val (MUL) or D <= rt_val (DIV); cnt <= 0; div_zero <= 0.
//  At accept, MUL: hi <= 0, lo <= rt_val, mcand <= rs_val.
//  At accept, DIV: hi <= 0, lo <= rs_val.
//  Divide by zero: hi <= rs_val, lo <= 32'hFFFFFFFF, div_zero <= 1; done pulses on the next cycle.
//  ALU alu_op encodings: ADD = 5'b00010, SUB = 5'b01110; ALU overflow and zero outputs are ignored.
//  MUL iteration, one per cycle:
//   A = hi, B = mcand, alu_op = ADD.
//   c = (hi[31] & mcand[31]) | ((hi[31] ^ mcand[31]) & ~S[31]).
//   If lo[0]: {hi,lo} <= {c, S, lo} >> 1; otherwise {hi,lo} <= {1'b0, hi, lo} >> 1.
//  DIV iteration (restoring), one per cycle:
//   Shift: {m, r} = {hi, lo[31]}, a 33-bit value; q = {lo[30:0], 1'b0}.
//   ALU: A = r, B = D, alu_op = SUB.
//   bw = (~r[31] & D[31]) | (~(r[31] ^ D[31]) & S[31]).
//   If m | ~bw: hi <= S, lo <= q | 1; otherwise hi <= r, lo <= q.
//  Latency: start accepted at edge k; 32 iterations at edges k+1 .. k+32.
//  done is high during the cycle after edge k+32, i.e. 33 cycles after accept; busy is low in that cycle.
//  hi/lo hold their value after done until the next accepted start or reset.
//  In IDLE and DONE, alu_op = ADD and A = B = 0, so the ALU outputs are deterministic.
// STRUCTURE
//  Shared include muldiv_defs.vh holds: state encodings (IDLE/MUL/DIV/DONE, 2 bits),
//  ALU_ADD / ALU_SUB alu_op constants, and OP_MULTU / OP_DIVU.
//  One sub-module: the existing ALU32, port order (A, alu_op, B, overflow, zero, S).
//  The FSM, counter and shift datapath live in this module.
// TESTING
//  MULTU 45 * 21 -> done exactly 33 cycles after accept; hi = 0, lo = 945.
//  MULTU 32'hFFFFFFFF * 32'hFFFFFFFF -> hi = 32'hFFFFFFFE, lo = 32'h00000001 (exercises the carry path).
//  DIVU 45 / 21 -> lo = 2, hi = 3; also 32'hFFFFFFFF / 32'h80000000 -> lo = 1, hi = 32'h7FFFFFFF (exercises the m bit).
//  DIVU 7 / 0 -> done on the cycle after accept; div_zero = 1, hi = 7, lo = 32'hFFFFFFFF.
//  start pulsed at iteration 10 with different operands -> ignored; the original result is delivered.
//  reset at iteration 10 -> next cycle busy = 0, hi = lo = 0; then MULTU 3 * 5 -> lo = 15.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// Shared types and constants for the iterative MULTU/DIVU unit.
// FSM state encoding, ALU32 opcodes and op selects.
package muldiv_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_XOR = 5'b00011;
  localparam logic [4:0] ALU_SUB = 5'b01110;

  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

endpackage

// File: rtl/muldiv_seq_alu32.sv
// ALU32: 32-bit combinational ALU used for every add/sub step.
// Ports: A, alu_op, B in; overflow, zero, S out.
module alu32
  import muldiv_seq_pkg::*;
(
  input  logic [31:0] A,
  input  logic [4:0]  alu_op,
  input  logic [31:0] B,
  output logic        overflow,
  output logic        zero,
  output logic [31:0] S
);

  always_comb begin
    S        = '0;
    overflow = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        S        = A + B;
        overflow = (A[31] == B[31]) && (S[31] != A[31]);
      end
      ALU_SUB: begin
        S        = A - B;
        overflow = (A[31] != B[31]) && (S[31] != A[31]);
      end
      ALU_AND: S = A & B;
      ALU_OR:  S = A | B;
      ALU_XOR: S = A ^ B;
      default: S = '0;
    endcase
  end

  assign zero = (S == '0);

endmodule

// File: rtl/muldiv_seq.sv
// Iterative unsigned MULTU/DIVU, one bit per clock, via ALU32.
// Ports: clk, reset, start, op, rs_val, rt_val in; busy, done, hi, lo, div_zero out.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  state_t state, state_n;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] d_reg;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [4:0]       alu_op;
  logic [WIDTH-1:0] alu_s;
  logic             unused_ovf;
  logic             unused_zero;

  logic             last;
  logic             mul_c;
  logic             div_m;
  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] div_q;
  logic             div_bw;

  alu32 u_alu (
    .A        (alu_a),
    .alu_op   (alu_op),
    .B        (alu_b),
    .overflow (unused_ovf),
    .zero     (unused_zero),
    .S        (alu_s)
  );

  assign last = (cnt == CNT_W'(WIDTH - 1));

  // Carry out of hi + mcand, rebuilt from the sum's MSB.
  assign mul_c = (hi[WIDTH-1] & mcand[WIDTH-1])
               | ((hi[WIDTH-1] ^ mcand[WIDTH-1]) & ~alu_s[WIDTH-1]);

  // Shifted partial remainder is 33 bits: {div_m, div_r}.
  assign div_m = hi[WIDTH-1];
  assign div_r = {hi[WIDTH-2:0], lo[WIDTH-1]};
  assign div_q = {lo[WIDTH-2:0], 1'b0};

  // Borrow out of div_r - d_reg, rebuilt from the difference's MSB.
  assign div_bw = (~div_r[WIDTH-1] & d_reg[WIDTH-1])
                | (~(div_r[WIDTH-1] ^ d_reg[WIDTH-1]) & alu_s[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MULTU)    state_n = S_MUL;
          else if (rt_val == '0) state_n = S_DONE;
          else                   state_n = S_DIV;
        end
      end
      S_MUL,
      S_DIV:  if (last) state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_ADD;
    case (state)
      S_MUL: begin
        busy   = 1'b1;
        alu_a  = hi;
        alu_b  = mcand;
        alu_op = ALU_ADD;
      end
      S_DIV: begin
        busy   = 1'b1;
        alu_a  = div_r;
        alu_b  = d_reg;
        alu_op = ALU_SUB;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      mcand    <= '0;
      d_reg    <= '0;
      cnt      <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            d_reg    <= rt_val;
            cnt      <= '0;
            div_zero <= 1'b0;
            if (op == OP_MULTU) begin
              hi    <= '0;
              lo    <= rt_val;
              mcand <= rs_val;
            end else if (rt_val == '0) begin
              hi       <= rs_val;
              lo       <= '1;
              div_zero <= 1'b1;
            end else begin
              hi <= '0;
              lo <= rs_val;
            end
          end
        end
        S_MUL: begin
          cnt <= cnt + 1'b1;
          if (lo[0]) {hi, lo} <= {mul_c, alu_s, lo[WIDTH-1:1]};
          else       {hi, lo} <= {1'b0, hi, lo[WIDTH-1:1]};
        end
        S_DIV: begin
          cnt <= cnt + 1'b1;
          if (div_m | ~div_bw) begin
            hi <= alu_s;
            lo <= div_q | {{(WIDTH-1){1'b0}}, 1'b1};
          end else begin
            hi <= div_r;
            lo <= div_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq.
// Random and directed MULTU/DIVU against an arithmetic reference model.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  int tests = 0;
  int fails = 0;

  muldiv_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  // Returns {div_zero, hi, lo}.
  function automatic logic [64:0] model(input logic o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    if (o == 1'b0) begin
      p = 64'(a) * 64'(b);
      return {1'b0, p};
    end
    if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
    return {1'b0, a % b, a / b};
  endfunction

  function automatic int model_lat(input logic o, input logic [31:0] b);
    return (o == 1'b1 && b == 0) ? 1 : 33;
  endfunction

  // Returns at the negedge of the cycle after the accepting edge (cycle 1).
  task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    @(negedge clk);
    start  = 1'b0;
    rs_val = $urandom;
    rt_val = $urandom;
  endtask

  // n = cycle index (after accept) at which done is seen; -1 on timeout.
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (done !== 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) n = -1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    op = 1'b0;
    rs_val = '0;
    rt_val = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, done, div_zero, hi, lo} !== 67'd0) begin
      fails++;
      $display("FAIL reset_state: got busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
               busy, done, div_zero, hi, lo);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL idle_quiet: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_directed;
    logic        t_op [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] t_a  [5] = '{32'd45, 32'hFFFF_FFFF, 32'd45, 32'hFFFF_FFFF, 32'd7};
    logic [31:0] t_b  [5] = '{32'd21, 32'hFFFF_FFFF, 32'd21, 32'h8000_0000, 32'd0};
    logic [31:0] t_hi [5] = '{32'd0, 32'hFFFF_FFFE, 32'd3, 32'h7FFF_FFFF, 32'd7};
    logic [31:0] t_lo [5] = '{32'd945, 32'd1, 32'd2, 32'd1, 32'hFFFF_FFFF};
    logic        t_dz [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int          t_n  [5] = '{33, 33, 33, 33, 1};
    int n;
    for (int i = 0; i < 5; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      wait_done(1, n);
      tests++;
      if (n !== t_n[i] || busy !== 1'b0) begin
        fails++;
        $display("FAIL dir_latency[%0d]: got cycle %0d busy=%b want cycle %0d busy=0",
                 i, n, busy, t_n[i]);
      end
      tests++;
      if (hi !== t_hi[i] || lo !== t_lo[i] || div_zero !== t_dz[i]) begin
        fails++;
        $display("FAIL dir_result[%0d]: got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b",
                 i, hi, lo, div_zero, t_hi[i], t_lo[i], t_dz[i]);
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || hi !== t_hi[i] || lo !== t_lo[i]) begin
        fails++;
        $display("FAIL dir_pulse_hold[%0d]: got done=%b hi=%h lo=%h want done=0 hi=%h lo=%h",
                 i, done, hi, lo, t_hi[i], t_lo[i]);
      end
    end
  endtask

  task automatic test_random;
    logic        o;
    logic [31:0] a, b;
    logic [64:0] e;
    int n;
    for (int i = 0; i < 24; i++) begin
      o = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = 32'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      e = model(o, a, b);
      issue(o, a, b);
      wait_done(1, n);
      tests++;
      if (n !== model_lat(o, b) || {div_zero, hi, lo} !== e) begin
        fails++;
        $display("FAIL rand[%0d] op=%b a=%h b=%h: got n=%0d dz=%b hi=%h lo=%h want n=%0d dz=%b hi=%h lo=%h",
                 i, o, a, b, n, div_zero, hi, lo, model_lat(o, b), e[64], e[63:32], e[31:0]);
      end
    end
  endtask

  task automatic test_start_ignored;
    logic [64:0] e;
    int n;
    e = model(1'b0, 32'd1234567, 32'd89);
    issue(1'b0, 32'd1234567, 32'd89);
    repeat (10) @(negedge clk);
    start  = 1'b1;
    op     = 1'b1;
    rs_val = 32'd5;
    rt_val = 32'd0;
    @(negedge clk);
    start = 1'b0;
    wait_done(12, n);
    tests++;
    if (n !== 33 || {div_zero, hi, lo} !== e) begin
      fails++;
      $display("FAIL start_ignored: got n=%0d dz=%b hi=%h lo=%h want n=33 dz=%b hi=%h lo=%h",
               n, div_zero, hi, lo, e[64], e[63:32], e[31:0]);
    end
  endtask

  task automatic test_reset_abort;
    int n;
    issue(1'b1, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      fails++;
      $display("FAIL reset_abort: got busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
               busy, done, hi, lo);
    end
    reset = 1'b0;
    issue(1'b0, 32'd3, 32'd5);
    wait_done(1, n);
    tests++;
    if (n !== 33 || hi !== 32'd0 || lo !== 32'd15) begin
      fails++;
      $display("FAIL after_abort_mul: got n=%0d hi=%h lo=%h want n=33 hi=0 lo=f",
               n, hi, lo);
    end
  endtask

  task automatic test_back_to_back;
    logic [64:0] e;
    int n;
    issue(1'b1, 32'hDEAD_BEEF, 32'd0);
    wait_done(1, n);
    issue(1'b0, 32'h0001_0001, 32'h0002_0003);
    tests++;
    if (div_zero !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL dz_clear: got dz=%b busy=%b want dz=0 busy=1", div_zero, busy);
    end
    e = model(1'b0, 32'h0001_0001, 32'h0002_0003);
    wait_done(1, n);
    repeat (5) @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || {hi, lo} !== e[63:0]) begin
      fails++;
      $display("FAIL b2b_hold: got done=%b busy=%b hi=%h lo=%h want 0 0 hi=%h lo=%h",
               done, busy, hi, lo, e[63:32], e[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
